// File: rtl/pushbutton_pio_pkg.sv
// pushbutton_pio_pkg: register map and sizing helpers shared by the
// push-button PIO top level and its per-bit debounce cell.
// Build option: PUSHBUTTON_PIO_DEBOUNCE_EN enables the debounce counters.
package pushbutton_pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_RSVD    = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_EDGECAP = 2'd3
  } pio_addr_e;

  // Bits needed to count 0..cycles-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pio_debounce.sv
// pio_debounce: one input bit -- 2-flop synchronizer, optional stability
// counter and the debounced level register.
// Build option: PUSHBUTTON_PIO_DEBOUNCE_EN selects the counter path;
// without it the debounced level simply follows the synchronizer.
module pio_debounce
  import pushbutton_pio_pkg::*;
#(
`ifdef PUSHBUTTON_PIO_DEBOUNCE_EN
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
`endif
  parameter logic        RESET_BIT       = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_deb
);

  logic r_sync1;
  logic r_sync2;
  logic r_deb;

  // Two-stage synchronizer for the asynchronous button input.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= RESET_BIT;
      r_sync2 <= RESET_BIT;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PUSHBUTTON_PIO_DEBOUNCE_EN
  localparam int unsigned  CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Count consecutive cycles of disagreement; accept the new level once the
  // count reaches its limit, and restart whenever the input returns.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_deb <= RESET_BIT;
    end else if (r_sync2 == r_deb) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= '0;
      r_deb <= r_sync2;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  // Debounced level tracks the synchronized input directly.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_deb <= RESET_BIT;
    end else begin
      r_deb <= r_sync2;
    end
  end
`endif

  assign o_deb = r_deb;

endmodule

// File: rtl/pushbutton_pio.sv
// pushbutton_pio: Avalon-MM input PIO for active-low push-buttons.
// Debounces each input, captures press (falling) edges, and raises a
// maskable level interrupt. Reads are zero-latency.
// Build option: PUSHBUTTON_PIO_DEBOUNCE_EN enables per-bit debounce counters.
module pushbutton_pio
  import pushbutton_pio_pkg::*;
#(
  parameter int unsigned      WIDTH           = 3,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("pushbutton_pio: WIDTH must be 1..32");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
    $error("pushbutton_pio: DEBOUNCE_CYCLES must be 1..65535");
  end

  logic [WIDTH-1:0] w_deb;
  logic [WIDTH-1:0] r_deb_d;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_wdata;
  logic [31:0]      w_unused_wdata;
  logic             w_wr;

  assign w_wdata        = writedata[WIDTH-1:0];
  assign w_unused_wdata = writedata;
  assign w_wr           = chipselect && !write_n;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce #(
`ifdef PUSHBUTTON_PIO_DEBOUNCE_EN
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`endif
      .RESET_BIT       (RESET_LEVEL[i])
    ) u_debounce (
      .i_clk   (clk),
      .i_reset (reset),
      .i_raw   (in_port[i]),
      .o_deb   (w_deb[i])
    );
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_deb_d <= RESET_LEVEL;
    end else begin
      r_deb_d <= w_deb;
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask <= '0;
    end else if (w_wr && (address == ADDR_IRQMASK)) begin
      r_mask <= w_wdata;
    end
  end

  assign w_set = r_deb_d & ~w_deb;
  assign w_clr = (w_wr && (address == ADDR_EDGECAP)) ? w_wdata : '0;

  // Press-edge capture; a set on the same edge as a clear keeps the bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_edgecap <= '0;
    end else begin
      r_edgecap <= (r_edgecap & ~w_clr) | w_set;
    end
  end

  // Zero-latency read mux; unused upper bits read as zero.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = w_deb;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = r_mask;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = r_edgecap;
      default:      readdata = '0;
    endcase
  end

  assign irq = |(r_edgecap & r_mask);

endmodule

// File: tb/tb_pushbutton_pio.sv
// tb_pushbutton_pio: directed checks of the push-button PIO with
// DEBOUNCE_CYCLES = 4. Build option: PUSHBUTTON_PIO_DEBOUNCE_EN.
module tb_pushbutton_pio;

`ifdef PUSHBUTTON_PIO_DEBOUNCE_EN
  localparam int D = 4;
`else
  localparam int D = 1;
`endif

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [2:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  pushbutton_pio #(
    .WIDTH           (3),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    address    = 2'd0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a,
                        input logic [31:0] exp);
    address = a;
    #1;
    check_vec(tag, readdata, exp);
  endtask

  task automatic irq_chk(input string tag, input logic exp);
    check_vec(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 3'b111;
    ticks(3);
    reset = 1'b0;
    tick();

    // Reset state
    rd_chk("rst_data", 2'd0, 32'h7);
    rd_chk("rst_rsvd", 2'd1, 32'h0);
    rd_chk("rst_mask", 2'd2, 32'h0);
    rd_chk("rst_cap",  2'd3, 32'h0);
    irq_chk("rst_irq", 1'b0);

    // Clean press of bit 1; in_port changes after edge 0
    in_port = 3'b101;
    ticks(1 + D);
    rd_chk("press_data_early", 2'd0, 32'h7);
    tick();
    rd_chk("press_data", 2'd0, 32'h5);
    rd_chk("press_cap_early", 2'd3, 32'h0);
    tick();
    rd_chk("press_cap", 2'd3, 32'h2);
    irq_chk("press_irq_masked", 1'b0);

    // Release is not captured
    in_port = 3'b111;
    ticks(D + 4);
    rd_chk("release_data", 2'd0, 32'h7);
    rd_chk("release_cap", 2'd3, 32'h2);
    wr(2'd0, 32'h0);
    rd_chk("data_ro", 2'd0, 32'h7);
    wr(2'd3, 32'h2);
    rd_chk("w1c_cap", 2'd3, 32'h0);

    // Bounce on bit 0: toggle every 2 cycles for 20 cycles, then hold 1
    for (int i = 0; i < 10; i++) begin
      in_port[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
      ticks(2);
    end
    ticks(D + 4);
    rd_chk("bounce_data", 2'd0, 32'h7);
`ifdef PUSHBUTTON_PIO_DEBOUNCE_EN
    rd_chk("bounce_cap", 2'd3, 32'h0);
`else
    rd_chk("bounce_cap", 2'd3, 32'h1);
    wr(2'd3, 32'h1);
`endif

    // Interrupt on bit 2 and W1C clear
    wr(2'd2, 32'hFFFF_FFFC);
    rd_chk("mask_rd", 2'd2, 32'h4);
    in_port = 3'b011;
    ticks(2 + D);
    irq_chk("irq_early", 1'b0);
    tick();
    irq_chk("irq_rise", 1'b1);
    rd_chk("irq_cap", 2'd3, 32'h4);
    wr(2'd3, 32'h4);
    irq_chk("irq_clr", 1'b0);
    rd_chk("irq_clr_cap", 2'd3, 32'h0);
    in_port = 3'b111;
    ticks(D + 4);

    // Simultaneous set and clear on bit 0
    wr(2'd2, 32'h1);
    in_port = 3'b110;
    ticks(3 + D);
    irq_chk("sim_first_irq", 1'b1);
    in_port = 3'b111;
    ticks(D + 4);
    irq_chk("sim_held_irq", 1'b1);
    in_port = 3'b110;
    ticks(2 + D);
    wr(2'd3, 32'h1);
    rd_chk("sim_cap", 2'd3, 32'h1);
    irq_chk("sim_irq", 1'b1);
    wr(2'd3, 32'h1);
    rd_chk("sim_clr_cap", 2'd3, 32'h0);
    irq_chk("sim_clr_irq", 1'b0);
    in_port = 3'b111;
    ticks(D + 4);

    // Reset part-way through a press of bit 1
    in_port = 3'b101;
    ticks(4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_chk("mid_rst_data", 2'd0, 32'h7);
    rd_chk("mid_rst_mask", 2'd2, 32'h0);
    rd_chk("mid_rst_cap",  2'd3, 32'h0);
    irq_chk("mid_rst_irq", 1'b0);
    ticks(1 + D);
    rd_chk("mid_rst_data_early", 2'd0, 32'h7);
    tick();
    rd_chk("mid_rst_data_late", 2'd0, 32'h5);
    tick();
    rd_chk("mid_rst_cap_late", 2'd3, 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
